snn_upsample2d: RTL and testbench
=================================

# snn_upsample2d

Spike-domain nearest-neighbour upsampling (unpooling) layer: the inverse of the 2D pooling stage. Each accepted input spike at (ch, y, x) is expanded into SCALE×SCALE output spikes covering (ch, y·SCALE+dy, x·SCALE+dx). It sits downstream of pooling/encoder stages in decoder or skip-connection paths. It uses the same 32-bit AXI-Stream spike packet on both ports.

## Interface
- IN_WIDTH, 14, input feature map width (IN_WIDTH·SCALE ≤ 256)
- IN_HEIGHT, 14, input feature map height (IN_HEIGHT·SCALE ≤ 256)
- CHANNELS, 32, number of channels (≤ 256)
- SCALE, 2, upsampling factor per axis (1..8)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  gates acceptance of new input spikes
- s_axis_input_tdata  in  32  [31:24] valid flag (non-zero = spike), [23:16] ch, [15:8] y, [7:0] x
- s_axis_input_tvalid  in  1  input beat valid
- s_axis_input_tready  out  1  block can accept a beat
- s_axis_input_tlast  in  1  end-of-timestep marker
- m_axis_output_tdata  out  32  {8'h01, ch, y_out, x_out}
- m_axis_output_tvalid  out  1  output beat valid
- m_axis_output_tready  in  1  downstream ready
- m_axis_output_tlast  out  1  end-of-timestep marker
- input_spike_count  out  32  accepted, in-bounds spikes
- output_spike_count  out  32  output handshakes completed
- dropped_count  out  32  beats consumed but discarded
- busy  out  1  expansion in progress

## Operation
- FSM states: IDLE, EMIT.
- IDLE: s_axis_input_tready = enable. On handshake (tvalid & tready):
  - valid flag ≠ 0 and x < IN_WIDTH and y < IN_HEIGHT and ch < CHANNELS: latch ch/x/y/tlast, set dx = dy = 0, go to EMIT, increment input_spike_count.
  - Otherwise: discard the beat, increment dropped_count, stay in IDLE. The tlast of a dropped beat is discarded.
- EMIT: s_axis_input_tready = 0, busy = 1. m_axis_output_tvalid = 1 with data {8'h01, ch, y·SCALE+dy, x·SCALE+dx}.
  - Emission order is raster: dy outer, dx inner.
  - On each output handshake: increment output_spike_count, then advance dx; when dx wraps to 0, advance dy.
  - After the handshake with dx = dy = SCALE−1, return to IDLE.
- m_axis_output_tlast = latched tlast only on the final beat (dx = dy = SCALE−1), else 0.
- Output coordinate arithmetic is 8-bit unsigned. The parameter constraints guarantee no overflow.
- All counters are 32-bit and wrap modulo 2^32.
- enable deasserted during EMIT: the current expansion completes; only new acceptance is blocked.
- Output data is held stable while m_axis_output_tvalid = 1 and m_axis_output_tready = 0.
- tvalid is never deasserted before its handshake, except by reset.

## Timing
- Reset values: s_axis_input_tready 0 during reset and enable-dependent thereafter. m_axis_output_tvalid 0, m_axis_output_tlast 0, m_axis_output_tdata 0, all counters 0, busy 0. State IDLE.
- Latency: input handshake at cycle N → first output beat valid at N+1.
- With m_axis_output_tready held high, beats are emitted at N+1 … N+SCALE².
- s_axis_input_tready reasserts at N+SCALE²+1. Sustained throughput is therefore one input per SCALE²+1 cycles.
- Dropped beats take one cycle each; tready stays high, so back-to-back drops are possible.
- Reset asserted mid-expansion: the partial expansion is discarded. All outputs take reset values on the next edge, and no further beats of that expansion appear.
- Simultaneous final output handshake and new s_axis_input_tvalid: the input is not accepted that cycle, because tready is 0 in EMIT.

## Test plan
- Single spike, SCALE=2: input {8'h01, ch=3, y=4, x=5}, m_tready=1 → outputs (y,x) = (8,10), (8,11), (9,10), (9,11), all ch=3, on consecutive cycles starting N+1. input_spike_count=1, output_spike_count=4.
- Backpressure: same input, m_tready toggling 1,0,0,1,… → data held stable while stalled, order unchanged, exactly 4 handshakes, s_tready low until the cycle after the 4th.
- tlast: input with tlast=1 at (0,0) → only the 4th output (1,1) carries tlast=1. A following input without tlast gives tlast=0 on all beats.
- Drops: beats with valid flag 0, x=14, and ch=32 → no output, dropped_count=3, input_spike_count=0, tready stays 1 each cycle.
- Reset mid-expansion: reset asserted after the 2nd output handshake → tvalid 0 next cycle, counters 0, no residual beats. A new input afterwards expands normally.
- SCALE=3, input (y=13, x=13) → 9 beats covering y 39..41 and x 39..41 in raster order.

Source files
------------

// File: rtl/snn_upsample2d_if.sv
// Spike packet stream bundle, shared by the input and output sides of the
// upsampling layer.
//   tdata  : {valid/flag[31:24], ch[23:16], y[15:8], x[7:0]}
//   tvalid : beat valid (master -> slave)
//   tready : slave can accept (slave -> master)
//   tlast  : end-of-timestep marker (master -> slave)
interface snn_upsample2d_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/snn_upsample2d.sv
// Spike-domain nearest-neighbour upsampling. Every accepted in-bounds spike
// at (ch, y, x) is expanded into SCALE x SCALE output spikes at
// (ch, y*SCALE+dy, x*SCALE+dx), emitted in raster order (dy outer, dx inner).
// Out-of-bounds or flag-zero beats are consumed and counted as dropped.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   enable              : gates acceptance of new input spikes
//   s_axis_input        : input spike stream (slave)
//   m_axis_output       : output spike stream (master)
//   input_spike_count   : accepted in-bounds spikes
//   output_spike_count  : completed output handshakes
//   dropped_count       : consumed but discarded beats
//   busy                : expansion in progress
//
// state | meaning
// IDLE  | waiting for an input beat, tready follows enable
// EMIT  | presenting the SCALE*SCALE expanded beats
module snn_upsample2d #(
    parameter int IN_WIDTH  = 14,
    parameter int IN_HEIGHT = 14,
    parameter int CHANNELS  = 32,
    parameter int SCALE     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    snn_upsample2d_if.slave         s_axis_input,
    snn_upsample2d_if.master        m_axis_output,
    output logic [31:0]             input_spike_count,
    output logic [31:0]             output_spike_count,
    output logic [31:0]             dropped_count,
    output logic                    busy
);

    typedef enum logic {IDLE, EMIT} state_t;

    // 9-bit limits so CHANNELS = 256 still compares correctly against 8-bit fields
    localparam logic [8:0] W_LIM = 9'(IN_WIDTH);
    localparam logic [8:0] H_LIM = 9'(IN_HEIGHT);
    localparam logic [8:0] C_LIM = 9'(CHANNELS);
    localparam logic [3:0] S_MAX = 4'(SCALE - 1);

    state_t      state_q, state_d;
    logic [7:0]  ch_q, ch_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  x_q, x_d;
    logic        last_q, last_d;
    logic [3:0]  dx_q, dx_d;
    logic [3:0]  dy_q, dy_d;
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    logic        s_tready;
    logic        in_hs;
    logic        in_ok;
    logic        out_hs;
    logic        final_beat;
    logic [7:0]  y_out;
    logic [7:0]  x_out;

    // tready is forced low while reset is held so nothing is consumed then
    assign s_tready   = (state_q == IDLE) & enable & ~reset;
    assign in_hs      = s_axis_input.tvalid & s_tready;
    assign in_ok      = (s_axis_input.tdata[31:24] != 8'd0)
                      & ({1'b0, s_axis_input.tdata[7:0]}   < W_LIM)
                      & ({1'b0, s_axis_input.tdata[15:8]}  < H_LIM)
                      & ({1'b0, s_axis_input.tdata[23:16]} < C_LIM);
    assign out_hs     = (state_q == EMIT) & m_axis_output.tready;
    assign final_beat = (dx_q == S_MAX) & (dy_q == S_MAX);

    assign y_out = 8'(32'(y_q) * SCALE) + {4'd0, dy_q};
    assign x_out = 8'(32'(x_q) * SCALE) + {4'd0, dx_q};

    assign s_axis_input.tready  = s_tready;
    assign m_axis_output.tvalid = (state_q == EMIT);
    assign m_axis_output.tdata  = (state_q == EMIT) ? {8'h01, ch_q, y_out, x_out} : 32'd0;
    assign m_axis_output.tlast  = (state_q == EMIT) & last_q & final_beat;
    assign busy                 = (state_q == EMIT);

    assign input_spike_count  = in_cnt_q;
    assign output_spike_count = out_cnt_q;
    assign dropped_count      = drop_cnt_q;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        y_d        = y_q;
        x_d        = x_q;
        last_d     = last_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    if (in_ok) begin
                        ch_d     = s_axis_input.tdata[23:16];
                        y_d      = s_axis_input.tdata[15:8];
                        x_d      = s_axis_input.tdata[7:0];
                        last_d   = s_axis_input.tlast;
                        dx_d     = 4'd0;
                        dy_d     = 4'd0;
                        in_cnt_d = in_cnt_q + 32'd1;
                        state_d  = EMIT;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                end
            end
            EMIT: begin
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + 32'd1;
                    if (dx_q == S_MAX) begin
                        dx_d = 4'd0;
                        if (dy_q == S_MAX) begin
                            dy_d    = 4'd0;
                            state_d = IDLE;
                        end else begin
                            dy_d = dy_q + 4'd1;
                        end
                    end else begin
                        dx_d = dx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ch_q       <= 8'd0;
            y_q        <= 8'd0;
            x_q        <= 8'd0;
            last_q     <= 1'b0;
            dx_q       <= 4'd0;
            dy_q       <= 4'd0;
            in_cnt_q   <= 32'd0;
            out_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            y_q        <= y_d;
            x_q        <= x_d;
            last_q     <= last_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_snn_upsample2d.sv
module tb_snn_upsample2d;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    always #5 clk = ~clk;

    snn_upsample2d_if s2();
    snn_upsample2d_if m2();
    snn_upsample2d_if s3();
    snn_upsample2d_if m3();

    logic [31:0] ic2, oc2, dc2, ic3, oc3, dc3;
    logic        busy2, busy3;

    snn_upsample2d #(.IN_WIDTH(14), .IN_HEIGHT(14), .CHANNELS(32), .SCALE(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable),
        .s_axis_input(s2), .m_axis_output(m2),
        .input_spike_count(ic2), .output_spike_count(oc2),
        .dropped_count(dc2), .busy(busy2));

    snn_upsample2d #(.IN_WIDTH(14), .IN_HEIGHT(14), .CHANNELS(32), .SCALE(3)) dut3 (
        .clk(clk), .reset(reset), .enable(enable),
        .s_axis_input(s3), .m_axis_output(m3),
        .input_spike_count(ic3), .output_spike_count(oc3),
        .dropped_count(dc3), .busy(busy3));

    int tests = 0;
    int fails = 0;

    // expected output beats {tlast, tdata}, filled when an input is accepted
    logic [32:0] q2[$];
    logic [32:0] q3[$];
    int exp_out2 = 0, exp_out3 = 0;
    int last_seen2 = 0, last_seen3 = 0;
    logic stall2 = 0, stall3 = 0;
    logic [31:0] prev2 = 0, prev3 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // nearest-neighbour expansion straight from the layer definition
    task automatic push_exp(input int inst, input logic [7:0] ch, input logic [7:0] y,
                            input logic [7:0] x, input bit last);
        int s;
        logic [32:0] e;
        logic [7:0] yo, xo;
        s = (inst == 2) ? 2 : 3;
        for (int dy = 0; dy < s; dy++)
            for (int dx = 0; dx < s; dx++) begin
                yo = 8'(int'(y) * s + dy);
                xo = 8'(int'(x) * s + dx);
                e = {last && (dy == s - 1) && (dx == s - 1), 8'h01, ch, yo, xo};
                if (inst == 2) q2.push_back(e); else q3.push_back(e);
            end
    endtask

    // called at posedge+1; returns at posedge+1 right after the input handshake
    task automatic send(input int inst, input logic [31:0] d, input bit last);
        int n;
        logic rdy;
        bit ok;
        ok = (d[31:24] != 0) && (d[7:0] < 14) && (d[15:8] < 14) && (d[23:16] < 32);
        if (inst == 2) begin s2.tdata = d; s2.tlast = last; s2.tvalid = 1'b1; end
        else           begin s3.tdata = d; s3.tlast = last; s3.tvalid = 1'b1; end
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (inst == 2) ? s2.tready : s3.tready;
            if (rdy) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 64'd0, 64'd1);
                s2.tvalid = 1'b0; s3.tvalid = 1'b0;
                return;
            end
        end
        if (ok) push_exp(inst, d[23:16], d[15:8], d[7:0], last);
        @(posedge clk); #1;
        s2.tvalid = 1'b0; s2.tlast = 1'b0;
        s3.tvalid = 1'b0; s3.tlast = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // compare processes: every handshake is checked against the expected queue
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            q2.delete(); exp_out2 = 0; last_seen2 = 0; stall2 = 0;
        end else begin
            chk("ocnt2", 64'(oc2), 64'(exp_out2));
            if (m2.tvalid && stall2) chk("hold2", 64'(m2.tdata), 64'(prev2));
            if (m2.tvalid && m2.tready) begin
                if (q2.size() == 0) chk("extra_beat2", 64'(m2.tdata), 64'd0);
                else begin
                    e = q2.pop_front();
                    chk("beat2", {31'd0, m2.tlast, m2.tdata}, 64'(e));
                end
                exp_out2++;
                if (m2.tlast) last_seen2++;
            end
            stall2 = m2.tvalid && !m2.tready;
            prev2 = m2.tdata;
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            q3.delete(); exp_out3 = 0; last_seen3 = 0; stall3 = 0;
        end else begin
            chk("ocnt3", 64'(oc3), 64'(exp_out3));
            if (m3.tvalid && stall3) chk("hold3", 64'(m3.tdata), 64'(prev3));
            if (m3.tvalid && m3.tready) begin
                if (q3.size() == 0) chk("extra_beat3", 64'(m3.tdata), 64'd0);
                else begin
                    e = q3.pop_front();
                    chk("beat3", {31'd0, m3.tlast, m3.tdata}, 64'(e));
                end
                exp_out3++;
                if (m3.tlast) last_seen3++;
            end
            stall3 = m3.tvalid && !m3.tready;
            prev3 = m3.tdata;
        end
    end

    logic [31:0] lit2 [4];
    bit pat [4];

    initial begin
        int hs;
        s2.tvalid = 0; s2.tdata = 0; s2.tlast = 0; m2.tready = 1;
        s3.tvalid = 0; s3.tdata = 0; s3.tlast = 0; m3.tready = 1;
        lit2[0] = 32'h0103_080A; lit2[1] = 32'h0103_080B;
        lit2[2] = 32'h0103_090A; lit2[3] = 32'h0103_090B;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_tready", 64'(s2.tready), 64'd0);
        chk("rst_tvalid", 64'(m2.tvalid), 64'd0);
        chk("rst_tdata", 64'(m2.tdata), 64'd0);
        chk("rst_cnts", {ic2, dc2}, 64'd0);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("idle_tready", 64'(s2.tready), 64'd1);
        chk("idle_busy", 64'(busy2), 64'd0);
        @(posedge clk); #1;

        // single spike, full-rate output
        send(2, 32'h0103_0405, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", 64'(m2.tvalid), 64'd1);
            chk("t1_tready", 64'(s2.tready), 64'd0);
            chk("t1_busy", 64'(busy2), 64'd1);
            chk("t1_data", 64'(m2.tdata), 64'(lit2[k]));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t1_tready_back", 64'(s2.tready), 64'd1);
        chk("t1_valid_done", 64'(m2.tvalid), 64'd0);
        chk("t1_icnt", 64'(ic2), 64'd1);
        chk("t1_ocnt", 64'(oc2), 64'd4);
        @(posedge clk); #1;

        // backpressure
        do_reset();
        m2.tready = pat[0];
        send(2, 32'h0103_0405, 1'b0);
        hs = 0;
        for (int i = 0; i < 40 && hs < 4; i++) begin
            m2.tready = pat[i % 4];
            @(negedge clk);
            chk("bp_tready_low", 64'(s2.tready), 64'd0);
            if (m2.tvalid && m2.tready) hs++;
            @(posedge clk); #1;
        end
        chk("bp_hs", 64'(hs), 64'd4);
        m2.tready = 1;
        @(negedge clk);
        chk("bp_tready_back", 64'(s2.tready), 64'd1);
        chk("bp_ocnt", 64'(oc2), 64'd4);
        @(posedge clk); #1;

        // tlast only on the final beat of a tlast input
        do_reset();
        send(2, 32'h0100_0000, 1'b1);
        cycles(6);
        send(2, 32'h0101_0203, 1'b0);
        cycles(6);
        chk("tlast_count", 64'(last_seen2), 64'd1);

        // back-to-back drops: flag 0, x=14, ch=32
        do_reset();
        s2.tvalid = 1;
        s2.tdata = 32'h0003_0405;
        @(negedge clk); chk("drop_rdy0", 64'(s2.tready), 64'd1);
        @(posedge clk); #1 s2.tdata = 32'h0103_040E;
        @(negedge clk); chk("drop_rdy1", 64'(s2.tready), 64'd1);
        @(posedge clk); #1 s2.tdata = 32'h0120_0405;
        @(negedge clk); chk("drop_rdy2", 64'(s2.tready), 64'd1);
        @(posedge clk); #1 s2.tvalid = 0;
        cycles(3);
        chk("drop_dcnt", 64'(dc2), 64'd3);
        chk("drop_icnt", 64'(ic2), 64'd0);
        chk("drop_ocnt", 64'(oc2), 64'd0);

        // boundary: largest in-bounds coordinates
        send(2, 32'h011F_0D0D, 1'b0);
        @(negedge clk);
        chk("edge_first", 64'(m2.tdata), 64'h011F_1A1A);
        @(posedge clk); #1;
        cycles(5);
        chk("edge_icnt", 64'(ic2), 64'd1);

        // reset mid-expansion
        do_reset();
        send(2, 32'h0103_0405, 1'b0);
        cycles(2);
        reset = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst_valid", 64'(m2.tvalid), 64'd0);
        chk("mrst_cnt", {ic2, oc2}, 64'd0);
        @(posedge clk); #1;
        reset = 0;
        cycles(5);
        chk("mrst_quiet", 64'(oc2), 64'd0);
        send(2, 32'h0107_0602, 1'b1);
        cycles(6);
        chk("mrst_icnt", 64'(ic2), 64'd1);
        chk("mrst_ocnt", 64'(oc2), 64'd4);

        // enable gating, and enable dropped during an expansion
        enable = 0;
        s2.tdata = 32'h0101_0101; s2.tvalid = 1;
        @(negedge clk); chk("en_tready", 64'(s2.tready), 64'd0);
        @(posedge clk); #1 s2.tvalid = 0;
        chk("en_icnt", 64'(ic2), 64'd1);
        enable = 1;
        send(2, 32'h0101_0101, 1'b0);
        enable = 0;
        cycles(6);
        chk("en_emit_done", 64'(oc2), 64'd8);
        chk("en_tready_off", 64'(s2.tready), 64'd0);
        enable = 1;

        // SCALE=3 corner
        send(3, 32'h0105_0D0D, 1'b1);
        @(negedge clk);
        chk("s3_first", 64'(m3.tdata), 64'h0105_2727);
        @(posedge clk); #1;
        cycles(12);
        chk("s3_ocnt", 64'(oc3), 64'd9);
        chk("s3_last", 64'(last_seen3), 64'd1);
        chk("s3_tready", 64'(s3.tready), 64'd1);

        chk("q2_empty", 64'(q2.size()), 64'd0);
        chk("q3_empty", 64'(q3.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
